// File: rtl/pow_seq_if.sv
// Valid/ready stream bundle for the power unit: operands in, result and overflow flag out.
interface pow_seq_if #(
    parameter int DATA_WIDTH = 32,
    parameter int EXP_WIDTH  = 4
) ();
    logic                  pow_valid_in;
    logic                  pow_ready_in;
    logic [DATA_WIDTH-1:0] pow_data_in;
    logic [EXP_WIDTH-1:0]  pow_exp_in;
    logic                  pow_valid_out;
    logic                  pow_ready_out;
    logic [DATA_WIDTH-1:0] pow_data_out;
    logic                  pow_ovf_out;

    modport master (
        output pow_valid_in, pow_data_in, pow_exp_in, pow_ready_out,
        input  pow_ready_in, pow_valid_out, pow_data_out, pow_ovf_out
    );

    modport slave (
        input  pow_valid_in, pow_data_in, pow_exp_in, pow_ready_out,
        output pow_ready_in, pow_valid_out, pow_data_out, pow_ovf_out
    );
endinterface

// File: rtl/pow_seq.sv
// Fixed-point base**exp using right-to-left square-and-multiply on one shared
// pipelined signed multiplier; exponent is chosen per transaction.
module pow_seq #(
    parameter int DATA_WIDTH   = 32,
    parameter int FRACTION     = 24,
    parameter int EXP_WIDTH    = 4,
    parameter int MULT_LATENCY = 4,
    parameter bit SATURATE     = 1'b1
) (
    input  logic      clk,
    input  logic      rst,
    pow_seq_if.slave  bus
);
    localparam int DW    = DATA_WIDTH;
    localparam int PW    = 2 * DATA_WIDTH;
    localparam int CNT_W = (MULT_LATENCY > 1) ? $clog2(MULT_LATENCY) : 1;

    localparam logic [DW-1:0]    ONE   = DW'(1) << FRACTION;
    localparam logic [DW-1:0]    MAXV  = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]    MINV  = {1'b1, {(DW-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(MULT_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, CALC, WAIT, DONE} state_t;

    state_t                 state_q, state_d;
    logic [DW-1:0]          base_q, base_d;
    logic [DW-1:0]          res_q, res_d;
    logic [EXP_WIDTH-1:0]   e_q, e_d;
    logic                   ovf_q, ovf_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   op_mul_q, op_mul_d;
    logic [MULT_LATENCY-1:0][PW-1:0] prod_q, prod_d;

    logic                   accept;
    logic                   decide;
    logic [EXP_WIDTH-1:0]   e_dec;
    logic [DW-1:0]          mul_a, mul_b;
    logic [PW-1:0]          prod_last;
    logic [DW-FRACTION:0]   prod_hi;
    logic                   step_ovf;
    logic [DW-1:0]          wb_val;

    assign bus.pow_ready_in  = ~rst & (state_q == IDLE);
    assign bus.pow_valid_out = (state_q == DONE);
    assign bus.pow_data_out  = res_q;
    assign bus.pow_ovf_out   = ovf_q;
    assign accept            = bus.pow_valid_in & bus.pow_ready_in;

    // Writeback path: take the Q-format window, flag if the discarded high bits are not a sign run.
    assign prod_last = prod_q[MULT_LATENCY-1];
    assign prod_hi   = prod_last[PW-1:FRACTION+DW-1];
    assign step_ovf  = ~((&prod_hi) | ~(|prod_hi));
    assign wb_val    = (SATURATE && step_ovf) ? (prod_last[PW-1] ? MINV : MAXV)
                                              : prod_last[FRACTION+DW-1:FRACTION];

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        res_d    = res_q;
        e_d      = e_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        op_mul_d = op_mul_q;
        decide   = 1'b0;
        e_dec    = e_q;
        case (state_q)
            IDLE: if (accept) begin
                base_d  = bus.pow_data_in;
                res_d   = ONE;
                e_d     = bus.pow_exp_in;
                ovf_d   = 1'b0;
                state_d = CALC;
            end
            CALC: decide = 1'b1;
            WAIT: if (cnt_q == LAST) begin
                decide = 1'b1;
                if (op_mul_q) begin
                    res_d = wb_val;
                    e_dec = e_q & ~EXP_WIDTH'(1);
                end else begin
                    base_d = wb_val;
                    e_dec  = e_q >> 1;
                end
                e_d   = e_dec;
                ovf_d = ovf_q | step_ovf;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            DONE: if (bus.pow_ready_out) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Writeback and the next issue share an edge so each op costs exactly MULT_LATENCY cycles.
        if (decide) begin
            cnt_d = '0;
            if (e_dec == '0) begin
                state_d = DONE;
            end else begin
                state_d  = WAIT;
                op_mul_d = e_dec[0];
            end
        end
    end

    // Operands come from the post-writeback values so a chained op sees the fresh result.
    always_comb begin
        mul_a     = base_d;
        mul_b     = e_dec[0] ? res_d : base_d;
        prod_d    = prod_q;
        prod_d[0] = PW'($signed({{DW{mul_a[DW-1]}}, mul_a}) * $signed({{DW{mul_b[DW-1]}}, mul_b}));
        for (int i = 1; i < MULT_LATENCY; i++) prod_d[i] = prod_q[i-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            base_q   <= '0;
            res_q    <= '0;
            e_q      <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            op_mul_q <= 1'b0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            res_q    <= res_d;
            e_q      <= e_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
            op_mul_q <= op_mul_d;
            prod_q   <= prod_d;
        end
    end
endmodule

// File: tb/tb_pow_seq.sv
// Scoreboard bench for pow_seq: a saturating and a wrapping instance, Q8.8, 4-cycle multiplier.
module tb_pow_seq;
    localparam int DW = 16;
    localparam int EW = 4;

    typedef struct {
        logic [DW-1:0] data;
        logic          ovf;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pow_seq_if #(.DATA_WIDTH(DW), .EXP_WIDTH(EW)) bus_s ();
    pow_seq_if #(.DATA_WIDTH(DW), .EXP_WIDTH(EW)) bus_w ();

    pow_seq #(.DATA_WIDTH(DW), .FRACTION(8), .EXP_WIDTH(EW), .MULT_LATENCY(4), .SATURATE(1'b1))
        u_sat (.clk(clk), .rst(rst), .bus(bus_s));
    pow_seq #(.DATA_WIDTH(DW), .FRACTION(8), .EXP_WIDTH(EW), .MULT_LATENCY(4), .SATURATE(1'b0))
        u_wrap (.clk(clk), .rst(rst), .bus(bus_w));

    logic          vin [2];
    logic [DW-1:0] din;
    logic [EW-1:0] ein;
    logic          rdy_o;

    assign bus_s.pow_valid_in  = vin[0];
    assign bus_w.pow_valid_in  = vin[1];
    assign bus_s.pow_data_in   = din;
    assign bus_w.pow_data_in   = din;
    assign bus_s.pow_exp_in    = ein;
    assign bus_w.pow_exp_in    = ein;
    assign bus_s.pow_ready_out = rdy_o;
    assign bus_w.pow_ready_out = rdy_o;

    logic          vo [2];
    logic          ri [2];
    logic [DW-1:0] dout [2];
    logic          oo [2];
    assign vo[0] = bus_s.pow_valid_out;  assign vo[1] = bus_w.pow_valid_out;
    assign ri[0] = bus_s.pow_ready_in;   assign ri[1] = bus_w.pow_ready_in;
    assign dout[0] = bus_s.pow_data_out; assign dout[1] = bus_w.pow_data_out;
    assign oo[0] = bus_s.pow_ovf_out;    assign oo[1] = bus_w.pow_ovf_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    exp_t q_s[$];
    exp_t q_w[$];
    exp_t cur [2];
    bit   active [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops on the rising valid, then checks the result every cycle it is held.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (vo[i] && !rst) begin
                if (!active[i]) begin
                    if ((i == 0) ? (q_s.size() == 0) : (q_w.size() == 0)) begin
                        check($sformatf("unexpected_valid[%0d]", i), 32'd1, 32'd0);
                        cur[i].data = dout[i];
                        cur[i].ovf  = oo[i];
                        cur[i].cyc  = cyc;
                    end else begin
                        cur[i] = (i == 0) ? q_s.pop_front() : q_w.pop_front();
                        check($sformatf("latency[%0d]", i), 32'(cyc), 32'(cur[i].cyc));
                    end
                    active[i] = 1'b1;
                end
                check($sformatf("data[%0d]", i), 32'(dout[i]), 32'(cur[i].data));
                check($sformatf("ovf[%0d]", i), 32'(oo[i]), 32'(cur[i].ovf));
                check($sformatf("ready_in_busy[%0d]", i), 32'(ri[i]), 32'd0);
                if (rdy_o) active[i] = 1'b0;
            end else if (rst) begin
                active[i] = 1'b0;
            end
        end
    end

    task automatic send(input int w, input logic [DW-1:0] d, input logic [EW-1:0] e,
                        input logic [DW-1:0] xd, input logic xo, input int lat, input bit push);
        exp_t x;
        int   n = 0;
        @(negedge clk);
        din = d; ein = e; vin[w] = 1'b1;
        while (!ri[w] && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!ri[w]) begin
            check("accept_timeout", 32'd0, 32'd1);
            vin[w] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        vin[w] = 1'b0;
        x.data = xd; x.ovf = xo; x.cyc = cyc + lat;
        if (push) begin
            if (w == 0) q_s.push_back(x);
            else        q_w.push_back(x);
        end
    endtask

    initial begin
        int n;
        vin[0] = 1'b0; vin[1] = 1'b0; din = '0; ein = '0; rdy_o = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_ready_in", 32'(ri[i]), 32'd0);
            check("rst_valid", 32'(vo[i]), 32'd0);
            check("rst_data", 32'(dout[i]), 32'd0);
            check("rst_ovf", 32'(oo[i]), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(ri[0]), 32'd1);

        send(0, 16'h0180, 4'd5,  16'h0798, 1'b0, 17, 1'b1);
        send(0, 16'hFE00, 4'd3,  16'hF800, 1'b0, 13, 1'b1);
        send(0, 16'hFE00, 4'd2,  16'h0400, 1'b0, 9,  1'b1);
        send(0, 16'h1000, 4'd2,  16'h7FFF, 1'b1, 9,  1'b1);
        send(1, 16'h1000, 4'd2,  16'h0000, 1'b1, 9,  1'b1);
        send(0, 16'hF000, 4'd3,  16'h8000, 1'b1, 13, 1'b1);
        send(0, 16'h5555, 4'd0,  16'h0100, 1'b0, 1,  1'b1);
        send(0, 16'h0123, 4'd1,  16'h0123, 1'b0, 5,  1'b1);
        send(0, 16'h0100, 4'd15, 16'h0100, 1'b0, 29, 1'b1);
        send(0, 16'h0181, 4'd2,  16'h0243, 1'b0, 9,  1'b1);
        send(0, 16'hFE7F, 4'd3,  16'hFC99, 1'b0, 13, 1'b1);
        send(1, 16'h0180, 4'd5,  16'h0798, 1'b0, 17, 1'b1);

        // Backpressure: hold the result for 10 cycles, then release.
        wait (q_s.size() == 0 && !vo[0]);
        rdy_o = 1'b0;
        send(0, 16'hFE00, 4'd3, 16'hF800, 1'b0, 13, 1'b1);
        n = 0;
        while (!vo[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", 32'(vo[0]), 32'd1);
        repeat (10) @(negedge clk);
        rdy_o = 1'b1;
        @(negedge clk);
        check("bp_idle_ready", 32'(ri[0]), 32'd1);
        check("bp_valid_low", 32'(vo[0]), 32'd0);
        send(0, 16'h0180, 4'd2, 16'h0240, 1'b0, 9, 1'b1);

        // Reset during WAIT aborts the transaction with no output.
        n = 0;
        while ((q_s.size() != 0 || active[0]) && n < 100) begin
            @(negedge clk);
            n++;
        end
        send(0, 16'h0180, 4'd7, 16'h0000, 1'b0, 0, 1'b0);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_valid", 32'(vo[0]), 32'd0);
        check("abort_data", 32'(dout[0]), 32'd0);
        check("abort_ovf", 32'(oo[0]), 32'd0);
        check("abort_ready_in", 32'(ri[0]), 32'd0);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        send(0, 16'h0180, 4'd2, 16'h0240, 1'b0, 9, 1'b1);

        n = 0;
        while ((q_s.size() != 0 || q_w.size() != 0 || active[0] || active[1]) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(q_s.size() + q_w.size()), 32'd0);
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
